target_spawner: RTL and testbench

- Consumes the slow-rolling pseudo-random value from random_number and turns it into falling targets on the playfield.
- Owns a small table of target slots: spawns on a frame-based period, advances active targets once per frame, retires targets that leave the screen (miss) or are hit by a shot (hit).
- Sits between the random source and the VGA renderer / collision logic, which read slots through a registered query port.

---
 rtl/game_pkg.sv | 34 +++
 rtl/target_spawner_free_slot_finder.sv | 29 ++
 rtl/target_spawner.sv | 195 +++++++++++++++++++
 tb/tb_target_spawner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: FSM state encoding, screen geometry and the target slot record.
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SPAWN = 2'd2
  } state_t;

  localparam int         SCREEN_W     = 640;
  localparam int         SCREEN_H     = 480;
  localparam logic [8:0] X_OFFSET_DEF = 9'd40;
  localparam logic [8:0] X_RANGE_DEF  = 9'd400;
  localparam logic [8:0] Y_LIMIT_DEF  = 9'd440;

  typedef struct packed {
    logic       active;
    logic [8:0] x;
    logic [8:0] y;
  } slot_t;

  // Clamp the random value into the legal span, then shift by the left margin (wraps mod 512).
  function automatic logic [8:0] spawn_x(input logic [8:0] rnd, input logic [8:0] offset,
                                         input logic [8:0] range);
    logic [8:0] clamped;
    clamped = (rnd >= range) ? (range - 9'd1) : rnd;
    return offset + clamped;
  endfunction

endpackage

`default_nettype wire

// File: rtl/target_spawner_free_slot_finder.sv
// free_slot_finder: lowest-index free slot priority encoder.
`default_nettype none

module free_slot_finder
  import game_pkg::*;
#(
  parameter int N_SLOTS = 4,
  parameter int SLOT_W  = 2
) (
  input  logic [N_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]  idx,
  output logic               found
);

  // Walk downwards so the lowest free index is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        idx   = SLOT_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/target_spawner.sv
// target_spawner: spawns, advances and retires falling targets from a slot table.
// Optional SPAWN_ACCEL_EN: spawn period shrinks by one per successful spawn, floor 15.
`default_nettype none

module target_spawner
  import game_pkg::*;
#(
  parameter int         N_SLOTS      = 4,
  parameter int         SLOT_W       = 2,
  parameter logic [8:0] X_OFFSET     = X_OFFSET_DEF,
  parameter logic [8:0] X_RANGE      = X_RANGE_DEF,
  parameter logic [8:0] Y_START      = 9'd0,
  parameter logic [8:0] Y_LIMIT      = Y_LIMIT_DEF,
  parameter logic [8:0] FALL_STEP    = 9'd2,
  parameter logic [7:0] SPAWN_PERIOD = 8'd60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        rand_in,
  input  logic              frame_tick,
  input  logic              hit_valid,
  input  logic [SLOT_W-1:0] hit_slot,
  input  logic [SLOT_W-1:0] q_slot,
  output logic              q_active,
  output logic [8:0]        q_x,
  output logic [8:0]        q_y,
  output logic              spawn_pulse,
  output logic              spawn_drop,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] scan_idx_q, scan_idx_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  slot_t             slots_q [N_SLOTS];
  slot_t             slots_d [N_SLOTS];
  logic [7:0]        hit_count_q, hit_count_d;
  logic [7:0]        miss_count_q, miss_count_d;
  logic              spawn_pulse_q, spawn_pulse_d;
  logic              spawn_drop_q, spawn_drop_d;
  logic              q_active_q, q_active_d;
  logic [8:0]        q_x_q, q_x_d;
  logic [8:0]        q_y_q, q_y_d;
  logic [7:0]        period_cur;

`ifdef SPAWN_ACCEL_EN
  logic [7:0] period_q, period_d;
  assign period_cur = period_q;
`else
  assign period_cur = SPAWN_PERIOD;
`endif

  logic              hit_now;
  logic [N_SLOTS-1:0] occupied;
  logic [SLOT_W-1:0] free_idx;
  logic              free_found;
  logic [9:0]        y_next;

  assign hit_now = hit_valid && slots_q[hit_slot].active;

  // A slot being hit this cycle is never offered to the spawner.
  for (genvar i = 0; i < N_SLOTS; i++) begin : g_occ
    assign occupied[i] = slots_q[i].active | (hit_valid && (hit_slot == SLOT_W'(i)));
  end

  free_slot_finder #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W)
  ) u_free_slot_finder (
    .occupied (occupied),
    .idx      (free_idx),
    .found    (free_found)
  );

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    frame_cnt_d   = frame_cnt_q;
    slots_d       = slots_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    spawn_pulse_d = 1'b0;
    spawn_drop_d  = 1'b0;
    y_next        = '0;
`ifdef SPAWN_ACCEL_EN
    period_d      = period_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d    = SCAN;
          scan_idx_d = '0;
        end
      end
      SCAN: begin
        y_next = {1'b0, slots_q[scan_idx_q].y} + {1'b0, FALL_STEP};
        if (slots_q[scan_idx_q].active && !(hit_now && (hit_slot == scan_idx_q))) begin
          if (y_next >= {1'b0, Y_LIMIT}) begin
            slots_d[scan_idx_q] = '0;
            if (miss_count_q != 8'hFF) miss_count_d = miss_count_q + 8'd1;
          end else begin
            slots_d[scan_idx_q].y = y_next[8:0];
          end
        end
        if (scan_idx_q == SLOT_W'(N_SLOTS - 1)) begin
          if (frame_cnt_q == period_cur - 8'd1) begin
            state_d = SPAWN;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = IDLE;
          end
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      SPAWN: begin
        frame_cnt_d = '0;
        if (free_found) begin
          slots_d[free_idx].active = 1'b1;
          slots_d[free_idx].x      = spawn_x(rand_in, X_OFFSET, X_RANGE);
          slots_d[free_idx].y      = Y_START;
          spawn_pulse_d            = 1'b1;
`ifdef SPAWN_ACCEL_EN
          if (period_q > 8'd15) period_d = period_q - 8'd1;
`endif
        end else begin
          spawn_drop_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Applied last so a hit overrides any scan update or retirement of the same slot.
    if (hit_now) begin
      slots_d[hit_slot] = '0;
      if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
    end
  end

  always_comb begin
    q_active_d = slots_q[q_slot].active;
    q_x_d      = slots_q[q_slot].x;
    q_y_d      = slots_q[q_slot].y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      frame_cnt_q   <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
      spawn_pulse_q <= 1'b0;
      spawn_drop_q  <= 1'b0;
      q_active_q    <= 1'b0;
      q_x_q         <= '0;
      q_y_q         <= '0;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= '0;
`ifdef SPAWN_ACCEL_EN
      period_q      <= SPAWN_PERIOD;
`endif
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      spawn_pulse_q <= spawn_pulse_d;
      spawn_drop_q  <= spawn_drop_d;
      q_active_q    <= q_active_d;
      q_x_q         <= q_x_d;
      q_y_q         <= q_y_d;
      for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= slots_d[i];
`ifdef SPAWN_ACCEL_EN
      period_q      <= period_d;
`endif
    end
  end

  assign q_active    = q_active_q;
  assign q_x         = q_x_q;
  assign q_y         = q_y_q;
  assign spawn_pulse = spawn_pulse_q;
  assign spawn_drop  = spawn_drop_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_target_spawner.sv
// Bench for target_spawner: spawn-timing scoreboard, long-run sequences and a spawn/drop table.
`default_nettype none

module tb_target_spawner;

  localparam int N_SLOTS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [8:0] rand_in;
  logic       frame_tick, hit_valid;
  logic [1:0] hit_slot, q_slot;
  logic       q_active, spawn_pulse, spawn_drop, busy;
  logic [8:0] q_x, q_y;
  logic [7:0] hit_count, miss_count;

  logic [8:0] rand_s;
  logic       frame_tick_s, hit_valid_s;
  logic [1:0] hit_slot_s, q_slot_s;
  logic       q_active_s, spawn_pulse_s, spawn_drop_s, busy_s;
  logic [8:0] q_x_s, q_y_s;
  logic [7:0] hit_count_s, miss_count_s;

  target_spawner u_dut (
    .clk(clk), .reset(reset), .rand_in(rand_in), .frame_tick(frame_tick),
    .hit_valid(hit_valid), .hit_slot(hit_slot), .q_slot(q_slot),
    .q_active(q_active), .q_x(q_x), .q_y(q_y),
    .spawn_pulse(spawn_pulse), .spawn_drop(spawn_drop),
    .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
  );

  // Short period instance used to reach a full table without any target falling out.
  target_spawner #(.SPAWN_PERIOD(8'd4)) u_small (
    .clk(clk), .reset(reset), .rand_in(rand_s), .frame_tick(frame_tick_s),
    .hit_valid(hit_valid_s), .hit_slot(hit_slot_s), .q_slot(q_slot_s),
    .q_active(q_active_s), .q_x(q_x_s), .q_y(q_y_s),
    .spawn_pulse(spawn_pulse_s), .spawn_drop(spawn_drop_s),
    .hit_count(hit_count_s), .miss_count(miss_count_s), .busy(busy_s)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int spawn_seen = 0, drop_seen = 0;
  int ps_cnt = 0, ds_cnt = 0;
  int fc_m = 0, per_m = 60;
  int exp_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every predicted spawn must show up on exactly its cycle.
  always @(negedge clk) begin
    if (spawn_drop) drop_seen++;
    if (spawn_pulse_s) ps_cnt++;
    if (spawn_drop_s) ds_cnt++;
    if (spawn_pulse) begin
      spawn_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spawn_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (exp_cyc != cyc) begin
          failures++;
          $display("FAIL spawn_timing: pulse at cycle %0d expected %0d", cyc, exp_cyc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL spawn_missing: no pulse at cycle %0d", exp_q[0]);
      exp_cyc = exp_q.pop_front();
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    fc_m  = 0;
    per_m = 60;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One frame on the main DUT; optional hit lands on the SCAN cycle of slot 0.
  task automatic main_tick(input bit with_hit, input logic [1:0] hslot, input bit dbl);
    @(negedge clk);
    frame_tick = 1'b1;
    if (fc_m == per_m - 1) begin
      exp_q.push_back(cyc + N_SLOTS + 2);
      fc_m = 0;
`ifdef SPAWN_ACCEL_EN
      if (per_m > 15) per_m--;
`endif
    end else begin
      fc_m++;
    end
    @(negedge clk);
    if (dbl) chk("busy_during_scan", busy, 1);
    frame_tick = dbl;
    hit_valid  = with_hit;
    hit_slot   = hslot;
    @(negedge clk);
    frame_tick = 1'b0;
    hit_valid  = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic query(input logic [1:0] s, output int a, output int x, output int y);
    @(negedge clk);
    q_slot = s;
    @(negedge clk);
    a = q_active;
    x = q_x;
    y = q_y;
  endtask

  task automatic query_s(input logic [1:0] s, output int a, output int x, output int y);
    @(negedge clk);
    q_slot_s = s;
    @(negedge clk);
    a = q_active_s;
    x = q_x_s;
    y = q_y_s;
  endtask

  task automatic small_tick();
    @(negedge clk);
    frame_tick_s = 1'b1;
    @(negedge clk);
    frame_tick_s = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [8:0] rnd;
    int         exp_pulse;
    int         exp_drop;
    logic [1:0] slot;
    int         exp_x;
    int         exp_y;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, x, y;
    reset = 1'b1; rand_in = 9'd100; frame_tick = 0; hit_valid = 0; hit_slot = 0; q_slot = 0;
    rand_s = 0; frame_tick_s = 0; hit_valid_s = 0; hit_slot_s = 0; q_slot_s = 0;

    tbl[0] = '{9'd100, 1, 0, 2'd0, 140, 0};
    tbl[1] = '{9'd511, 1, 0, 2'd1, 439, 0};
    tbl[2] = '{9'd0,   1, 0, 2'd2, 40,  0};
    tbl[3] = '{9'd399, 1, 0, 2'd3, 439, 0};
    tbl[4] = '{9'd400, 0, 1, 2'd0, 140, 32};

    // Reset state, first spawn, fall and miss retirement.
    do_reset();
    query(2'd0, a, x, y);
    chk("reset_q_active", a, 0);
    chk("reset_q_x", x, 0);
    chk("reset_q_y", y, 0);
    chk("reset_hit_count", hit_count, 0);
    chk("reset_miss_count", miss_count, 0);
    chk("reset_spawn_pulse", spawn_pulse, 0);
    chk("reset_spawn_drop", spawn_drop, 0);
    chk("reset_busy", busy, 0);

    spawn_seen = 0;
    drop_seen  = 0;
    for (int i = 1; i <= 60; i++) main_tick(0, 2'd0, 0);
    chk("spawns_after_60_ticks", spawn_seen, 1);
    query(2'd0, a, x, y);
    chk("first_spawn_active", a, 1);
    chk("first_spawn_x", x, 140);
    chk("first_spawn_y", y, 0);

    rand_in = 9'd511;
    for (int i = 61; i <= 279; i++) main_tick(0, 2'd0, 0);
    query(2'd0, a, x, y);
    chk("slot0_y_before_limit", y, 438);
    chk("slot0_active_before_limit", a, 1);
    main_tick(0, 2'd0, 0);
    query(2'd0, a, x, y);
    chk("slot0_retired", a, 0);
    chk("miss_count_after_retire", miss_count, 1);
    chk("hit_count_no_hits", hit_count, 0);
    query(2'd1, a, x, y);
    chk("slot1_active", a, 1);
    chk("slot1_clamped_x", x, 439);
    chk("main_no_drop", drop_seen, 0);
    chk("scoreboard_drained_a", exp_q.size(), 0);

    // Ignored busy tick, hit on an empty slot, hit beating a miss.
    do_reset();
    rand_in = 9'd100;
    main_tick(0, 2'd0, 1);
    @(negedge clk);
    hit_valid = 1'b1;
    hit_slot  = 2'd2;
    @(negedge clk);
    hit_valid = 1'b0;
    @(negedge clk);
    chk("hit_inactive_ignored", hit_count, 0);
    for (int i = 2; i <= 279; i++) main_tick(0, 2'd0, 0);
    query(2'd0, a, x, y);
    chk("b_slot0_y_before_limit", y, 438);
    main_tick(1, 2'd0, 0);
    chk("hit_beats_miss_hits", hit_count, 1);
    chk("hit_beats_miss_misses", miss_count, 0);
    query(2'd0, a, x, y);
    chk("b_slot0_cleared", a, 0);
    query(2'd1, a, x, y);
    chk("b_slot1_untouched", a, 1);
    chk("scoreboard_drained_b", exp_q.size(), 0);

    // Table: fill all slots on the short-period instance, then a dropped spawn.
    for (int i = 0; i < 5; i++) begin
      rand_s = tbl[i].rnd;
      ps_cnt = 0;
      ds_cnt = 0;
      repeat (4) small_tick();
      chk($sformatf("tbl%0d_spawn_pulse", i), ps_cnt, tbl[i].exp_pulse);
      chk($sformatf("tbl%0d_spawn_drop", i), ds_cnt, tbl[i].exp_drop);
      query_s(tbl[i].slot, a, x, y);
      chk($sformatf("tbl%0d_active", i), a, 1);
      chk($sformatf("tbl%0d_x", i), x, tbl[i].exp_x);
      chk($sformatf("tbl%0d_y", i), y, tbl[i].exp_y);
    end
    query_s(2'd3, a, x, y);
    chk("drop_slot3_x_kept", x, 439);
    chk("drop_slot3_y", y, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
